// File: rtl/w5300_receiver.sv
// W5300 socket-N receive engine: polls RX_RSR, drains one packet from RX_FIFOR into
// the local RX buffer and releases the space with a RECV command.
module w5300_receiver #(
    parameter logic [2:0]  N                   = 3'd0,
    parameter int unsigned ETH_RX_BUFFER_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           eth_rx_req,
    output logic [ETH_RX_BUFFER_WIDTH-1:0] eth_rx_buffer_addr,
    output logic [15:0]                    eth_rx_buffer_data,
    output logic                           eth_rx_buffer_we,
    output logic [15:0]                    rx_len,
    output logic                           rx_done,
    output logic                           rx_empty,
    output logic                           rx_overflow,
    output logic [9:0]                     addr,
    output logic                           wr,
    output logic [15:0]                    wr_data,
    input  logic [15:0]                    rd_data,
    input  logic                           op_state
);
    localparam logic [9:0]  SockBase  = 10'h200 + 10'({N, 6'h00});
    localparam logic [9:0]  AddrCr    = SockBase + 10'h002;
    localparam logic [9:0]  AddrRsr0  = SockBase + 10'h028;
    localparam logic [9:0]  AddrRsr2  = SockBase + 10'h02A;
    localparam logic [9:0]  AddrFifor = SockBase + 10'h030;
    localparam logic [15:0] CmdRecv   = 16'h0040;
    localparam logic [16:0] BufCap    = 17'd1 << ETH_RX_BUFFER_WIDTH;

    typedef enum logic [2:0] {
        StIdle, StReadRsr, StCheckRsr, StReadHeader, StReadFifo, StDoRecv, StPostRecv
    } state_e;

    state_e                        state_q, state_d;
    logic [1:0]                    op_cnt_q, op_cnt_d;
    logic [31:0]                   rsr_q, rsr_d;
    logic [16:0]                   words_q, words_d;
    logic [16:0]                   word_cnt_q, word_cnt_d;
    logic [9:0]                    addr_q, addr_d;
    logic                          wr_q, wr_d;
    logic [15:0]                   wr_data_q, wr_data_d;
    logic [ETH_RX_BUFFER_WIDTH-1:0] buf_addr_q, buf_addr_d;
    logic [15:0]                   buf_data_q, buf_data_d;
    logic                          buf_we_q, buf_we_d;
    logic [15:0]                   rx_len_q, rx_len_d;
    logic                          rx_done_q, rx_done_d;
    logic                          rx_empty_q, rx_empty_d;
    logic                          rx_overflow_q, rx_overflow_d;

    always_comb begin
        state_d       = state_q;
        op_cnt_d      = op_cnt_q;
        rsr_d         = rsr_q;
        words_d       = words_q;
        word_cnt_d    = word_cnt_q;
        addr_d        = addr_q;
        wr_d          = wr_q;
        wr_data_d     = wr_data_q;
        buf_addr_d    = buf_addr_q;
        buf_data_d    = buf_data_q;
        buf_we_d      = 1'b0;
        rx_len_d      = rx_len_q;
        rx_done_d     = 1'b0;
        rx_empty_d    = 1'b0;
        rx_overflow_d = rx_overflow_q;

        unique case (state_q)
            StIdle: begin
                addr_d    = 10'h000;
                wr_d      = 1'b0;
                wr_data_d = 16'h0000;
                if (eth_rx_req) begin
                    state_d       = StReadRsr;
                    rx_overflow_d = 1'b0;
                    buf_addr_d    = '0;
                    word_cnt_d    = 17'd0;
                    addr_d        = AddrRsr0;
                end
            end
            StReadRsr: begin
                if (op_state) begin
                    if (op_cnt_q == 2'd0) begin
                        rsr_d[31:16] = rd_data;
                        op_cnt_d     = 2'd1;
                        addr_d       = AddrRsr2;
                    end else begin
                        rsr_d[15:0] = rd_data;
                        state_d     = StCheckRsr;
                        addr_d      = 10'h000;
                        // Pulse lands in the CheckRsr cycle itself.
                        rx_empty_d  = ({rsr_q[31:16], rd_data} == 32'd0);
                    end
                end
            end
            StCheckRsr: begin
                if (rsr_q == 32'd0) begin
                    state_d = StIdle;
                end else begin
                    state_d = StReadHeader;
                    addr_d  = AddrFifor;
                end
            end
            StReadHeader: begin
                if (op_state) begin
                    rx_len_d   = rd_data;
                    words_d    = ({1'b0, rd_data} + 17'd1) >> 1;
                    word_cnt_d = 17'd0;
                    if (rd_data == 16'h0000) begin
                        state_d   = StDoRecv;
                        addr_d    = AddrCr;
                        wr_d      = 1'b1;
                        wr_data_d = CmdRecv;
                    end else begin
                        state_d = StReadFifo;
                    end
                end
            end
            StReadFifo: begin
                if (op_state) begin
                    if (word_cnt_q < BufCap) begin
                        buf_we_d   = 1'b1;
                        buf_data_d = rd_data;
                        buf_addr_d = word_cnt_q[ETH_RX_BUFFER_WIDTH-1:0];
                    end else begin
                        rx_overflow_d = 1'b1;
                    end
                    word_cnt_d = word_cnt_q + 17'd1;
                    if (word_cnt_q + 17'd1 == words_q) begin
                        state_d   = StDoRecv;
                        addr_d    = AddrCr;
                        wr_d      = 1'b1;
                        wr_data_d = CmdRecv;
                    end
                end
            end
            StDoRecv: begin
                if (op_state) begin
                    state_d   = StPostRecv;
                    addr_d    = 10'h000;
                    wr_d      = 1'b0;
                    wr_data_d = 16'h0000;
                    rx_done_d = 1'b1;
                end
            end
            StPostRecv: state_d = StIdle;
            default:    state_d = StIdle;
        endcase

        if (state_d != state_q) begin
            op_cnt_d = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            op_cnt_q      <= 2'd0;
            rsr_q         <= 32'd0;
            words_q       <= 17'd0;
            word_cnt_q    <= 17'd0;
            addr_q        <= 10'h000;
            wr_q          <= 1'b0;
            wr_data_q     <= 16'h0000;
            buf_addr_q    <= '0;
            buf_data_q    <= 16'h0000;
            buf_we_q      <= 1'b0;
            rx_len_q      <= 16'h0000;
            rx_done_q     <= 1'b0;
            rx_empty_q    <= 1'b0;
            rx_overflow_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_cnt_q      <= op_cnt_d;
            rsr_q         <= rsr_d;
            words_q       <= words_d;
            word_cnt_q    <= word_cnt_d;
            addr_q        <= addr_d;
            wr_q          <= wr_d;
            wr_data_q     <= wr_data_d;
            buf_addr_q    <= buf_addr_d;
            buf_data_q    <= buf_data_d;
            buf_we_q      <= buf_we_d;
            rx_len_q      <= rx_len_d;
            rx_done_q     <= rx_done_d;
            rx_empty_q    <= rx_empty_d;
            rx_overflow_q <= rx_overflow_d;
        end
    end

    assign addr               = addr_q;
    assign wr                 = wr_q;
    assign wr_data            = wr_data_q;
    assign eth_rx_buffer_addr = buf_addr_q;
    assign eth_rx_buffer_data = buf_data_q;
    assign eth_rx_buffer_we   = buf_we_q;
    assign rx_len             = rx_len_q;
    assign rx_done            = rx_done_q;
    assign rx_empty           = rx_empty_q;
    assign rx_overflow        = rx_overflow_q;

endmodule
